// File: rtl/ci_launcher_pkg.sv
// Shared definitions for the custom-instruction launcher: register map,
// CONTROL/STATUS bit positions and the sequencing FSM state type.
package ci_launcher_pkg;

    localparam logic [2:0] ADDR_CI_N    = 3'd0;
    localparam logic [2:0] ADDR_VALUE_A = 3'd1;
    localparam logic [2:0] ADDR_VALUE_B = 3'd2;
    localparam logic [2:0] ADDR_CTRL    = 3'd3;
    localparam logic [2:0] ADDR_RESULT  = 3'd4;

    localparam int CTRL_START_BIT  = 0;
    localparam int CTRL_IRQ_EN_BIT = 1;
    localparam int CTRL_CLEAR_BIT  = 2;

    localparam int STAT_BUSY_BIT    = 0;
    localparam int STAT_DONE_BIT    = 1;
    localparam int STAT_TIMEOUT_BIT = 2;
    localparam int STAT_IRQ_EN_BIT  = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } ci_state_e;

    function automatic logic [31:0] pack_status(input logic busy, input logic done,
                                                input logic timeout, input logic irq_en);
        logic [31:0] s;
        s = '0;
        s[STAT_BUSY_BIT]    = busy;
        s[STAT_DONE_BIT]    = done;
        s[STAT_TIMEOUT_BIT] = timeout;
        s[STAT_IRQ_EN_BIT]  = irq_en;
        return s;
    endfunction

endpackage

// File: rtl/ci_launcher_if.sv
// Custom-instruction handshake between a launcher (master) and a CI block (slave).
interface ci_launcher_if;
    logic [7:0]  ci_n;
    logic [31:0] ci_value_a;
    logic [31:0] ci_value_b;
    logic        ci_start;
    logic        ci_cke;
    logic        ci_done;
    logic [31:0] ci_result;

    modport master (
        output ci_n, ci_value_a, ci_value_b, ci_start, ci_cke,
        input  ci_done, ci_result
    );

    modport slave (
        input  ci_n, ci_value_a, ci_value_b, ci_start, ci_cke,
        output ci_done, ci_result
    );
endinterface

// File: rtl/ci_timeout_counter.sv
// Saturating 32-bit watchdog counter. expired_o flags the last allowed WAIT
// cycle (count == limit-1); a zero limit disables the watchdog entirely.
module ci_timeout_counter (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        clear_i,
    input  logic        enable_i,
    input  logic [31:0] limit_i,
    output logic        expired_o
);
    logic [31:0] count_q, count_d;

    // Clear has priority; counting stops at all-ones instead of wrapping.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && (count_q != '1)) begin
            count_d = count_q + 32'd1;
        end
    end

    // Count register.
    always_ff @(posedge clock_i) begin
        if (reset_i) count_q <= '0;
        else         count_q <= count_d;
    end

    assign expired_o = (limit_i != '0) && (count_q == (limit_i - 32'd1));

endmodule

// File: rtl/ci_launcher.sv
// Memory-mapped launcher for custom instructions: holds the operands, issues
// one start pulse, keeps the CI clocked until ciDone, captures the result and
// raises status/interrupt. An optional watchdog aborts a silent CI.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   ST_IDLE  | no transaction; register writes and start accepted
//   ST_ISSUE | single cycle: ci_start=1, ci_cke=1; done here = combinational CI
//   ST_WAIT  | ci_cke=1, waiting for ci_done or watchdog expiry
module ci_launcher
    import ci_launcher_pkg::*;
#(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd0
) (
    input  logic          clock_i,
    input  logic          reset_i,
    input  logic [2:0]    bus_address_i,
    input  logic          bus_write_enable_i,
    input  logic [31:0]   bus_write_data_i,
    input  logic          bus_read_enable_i,
    output logic [31:0]   bus_read_data_o,
    output logic          bus_read_valid_o,
    ci_launcher_if.master ci_if,
    output logic          irq_o
);
    ci_state_e   state_q, state_d;
    logic [7:0]  ci_n_q;
    logic [31:0] value_a_q, value_b_q, result_q;
    logic        done_q, timeout_q, irq_en_q;
    logic [31:0] rd_data_q, rd_mux;
    logic        rd_valid_q;
    logic        set_done, set_timeout, cnt_clear, cnt_enable, expired;
    logic        busy, wr_ctrl, start_req, flag_clear;

    assign busy      = (state_q != ST_IDLE);
    assign wr_ctrl   = bus_write_enable_i && (bus_address_i == ADDR_CTRL);
    assign start_req = wr_ctrl && bus_write_data_i[CTRL_START_BIT];
    // Accepting a start also wipes the previous transaction's flags.
    assign flag_clear = (wr_ctrl && bus_write_data_i[CTRL_CLEAR_BIT]) ||
                        (start_req && !busy);

    ci_timeout_counter u_watchdog (
        .clock_i   (clock_i),
        .reset_i   (reset_i),
        .clear_i   (cnt_clear),
        .enable_i  (cnt_enable),
        .limit_i   (TIMEOUT_CYCLES),
        .expired_o (expired)
    );

    // FSM state register.
    always_ff @(posedge clock_i) begin
        if (reset_i) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // Next state plus completion/watchdog strobes; done beats expiry.
    always_comb begin
        state_d     = state_q;
        set_done    = 1'b0;
        set_timeout = 1'b0;
        cnt_clear   = 1'b0;
        cnt_enable  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_req) begin
                    state_d   = ST_ISSUE;
                    cnt_clear = 1'b1;
                end
            end
            ST_ISSUE: begin
                if (ci_if.ci_done) begin
                    set_done = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (ci_if.ci_done) begin
                    set_done = 1'b1;
                    state_d  = ST_IDLE;
                end else if (expired) begin
                    set_timeout = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    cnt_enable = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Operand registers: frozen while a transaction is in flight.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            ci_n_q    <= '0;
            value_a_q <= '0;
            value_b_q <= '0;
        end else if (bus_write_enable_i && !busy) begin
            case (bus_address_i)
                ADDR_CI_N:    ci_n_q    <= bus_write_data_i[7:0];
                ADDR_VALUE_A: value_a_q <= bus_write_data_i;
                ADDR_VALUE_B: value_b_q <= bus_write_data_i;
                default: ;
            endcase
        end
    end

    // Result, flags and irq enable; a set event outranks a clear.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            result_q  <= '0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            irq_en_q  <= 1'b0;
        end else begin
            if (set_done)         result_q <= ci_if.ci_result;
            else if (set_timeout) result_q <= '0;

            if (set_done)        done_q <= 1'b1;
            else if (flag_clear) done_q <= 1'b0;

            if (set_timeout)     timeout_q <= 1'b1;
            else if (flag_clear) timeout_q <= 1'b0;

            if (wr_ctrl) irq_en_q <= bus_write_data_i[CTRL_IRQ_EN_BIT];
        end
    end

    // Read data selection.
    always_comb begin
        rd_mux = '0;
        case (bus_address_i)
            ADDR_CI_N:    rd_mux = {24'd0, ci_n_q};
            ADDR_VALUE_A: rd_mux = value_a_q;
            ADDR_VALUE_B: rd_mux = value_b_q;
            ADDR_CTRL:    rd_mux = pack_status(busy, done_q, timeout_q, irq_en_q);
            ADDR_RESULT:  rd_mux = result_q;
            default:      rd_mux = '0;
        endcase
    end

    // One-cycle read response; data is zero whenever valid is low.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= bus_read_enable_i;
            rd_data_q  <= bus_read_enable_i ? rd_mux : '0;
        end
    end

    assign bus_read_data_o  = rd_data_q;
    assign bus_read_valid_o = rd_valid_q;
    assign ci_if.ci_n       = ci_n_q;
    assign ci_if.ci_value_a = value_a_q;
    assign ci_if.ci_value_b = value_b_q;
    assign ci_if.ci_start   = (state_q == ST_ISSUE);
    assign ci_if.ci_cke     = busy;
    assign irq_o            = irq_en_q && (done_q || timeout_q);

endmodule

// File: tb/tb_ci_launcher.sv
// Bench for ci_launcher: scenario tasks drive a scripted CI responder and
// compare against a transaction-level model of the launcher's rules.
module tb_ci_launcher;
    import ci_launcher_pkg::*;

    localparam int TMO = 16;

    logic        clock = 1'b0;
    logic        reset;
    logic [2:0]  bus_addr;
    logic        bus_we, bus_re;
    logic [31:0] bus_wdata, bus_rdata;
    logic        bus_rvalid, irq;

    ci_launcher_if ci_bus();

    ci_launcher #(.TIMEOUT_CYCLES(32'(TMO))) dut (
        .clock_i            (clock),
        .reset_i            (reset),
        .bus_address_i      (bus_addr),
        .bus_write_enable_i (bus_we),
        .bus_write_data_i   (bus_wdata),
        .bus_read_enable_i  (bus_re),
        .bus_read_data_o    (bus_rdata),
        .bus_read_valid_o   (bus_rvalid),
        .ci_if              (ci_bus),
        .irq_o              (irq)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // transaction-level model
    logic [31:0] m_a, m_result;
    logic        m_done, m_tmo, m_irq_en;

    function automatic bit model_done(input int lat);
        return (lat > 0) && (lat <= TMO + 1);
    endfunction

    function automatic int model_busy(input int lat);
        return model_done(lat) ? lat : TMO + 1;
    endfunction

    function automatic logic [31:0] model_status();
        return {28'd0, m_irq_en, m_tmo, m_done, 1'b0};
    endfunction

    function automatic void model_finish(input int lat, input logic [31:0] val);
        m_done   = model_done(lat);
        m_tmo    = !model_done(lat);
        m_result = model_done(lat) ? val : 32'd0;
    endfunction

    // all bus tasks start and end just after a falling edge
    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        bus_we = 1'b1; bus_addr = a; bus_wdata = d;
        @(negedge clock);
        bus_we = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d, output logic v);
        bus_re = 1'b1; bus_addr = a;
        @(negedge clock);
        bus_re = 1'b0;
        d = bus_rdata;
        v = bus_rvalid;
    endtask

    // poke: 0 none, 1 writes while busy + mid status read, 2 clear in done cycle,
    //       3 spurious done in idle, 4 back-to-back start in first idle cycle
    task automatic run_txn(input int lat, input logic [31:0] val, input int poke,
                           input logic [31:0] poke_val, output int n_start,
                           output int busy, output int first_start,
                           output int last_start, output logic [31:0] mid_stat);
        n_start = 0; busy = 0; first_start = 0; last_start = 0; mid_stat = '0;
        bus_we = 1'b1; bus_addr = ADDR_CTRL; bus_wdata = {29'd0, 1'b0, m_irq_en, 1'b1};
        @(negedge clock);
        for (int k = 1; k <= 64; k++) begin
            bus_we = 1'b0; bus_re = 1'b0;
            if (ci_bus.ci_start) begin
                n_start++;
                if (first_start == 0) first_start = k;
                last_start = k;
            end
            if (ci_bus.ci_cke && busy == k - 1) busy = k;
            if (poke == 1 && k == 5) mid_stat = bus_rdata;
            ci_bus.ci_done   = (k == lat) || (poke == 3 && lat > 0 && k == lat + 3);
            ci_bus.ci_result = (k == lat) ? val : $urandom();
            if (poke == 1 && k == 2) begin
                bus_we = 1'b1; bus_addr = ADDR_VALUE_A; bus_wdata = poke_val;
            end
            if (poke == 1 && k == 3) begin
                bus_we = 1'b1; bus_addr = ADDR_CTRL; bus_wdata = {30'd0, m_irq_en, 1'b1};
            end
            if (poke == 1 && k == 4) begin
                bus_re = 1'b1; bus_addr = ADDR_CTRL;
            end
            if (poke == 2 && k == lat) begin
                bus_we = 1'b1; bus_addr = ADDR_CTRL; bus_wdata = {29'd0, 1'b1, m_irq_en, 1'b0};
            end
            if (poke == 4 && k == lat + 1) begin
                bus_we = 1'b1; bus_addr = ADDR_CTRL; bus_wdata = {30'd0, m_irq_en, 1'b1};
            end
            @(negedge clock);
        end
        bus_we = 1'b0; bus_re = 1'b0;
        ci_bus.ci_done = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d; logic v;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        total++; if (ci_bus.ci_start !== 1'b0 || ci_bus.ci_cke !== 1'b0 || irq !== 1'b0) begin
            bad++; $display("FAIL reset_outputs: got start=%b cke=%b irq=%b want 0 0 0",
                            ci_bus.ci_start, ci_bus.ci_cke, irq); end
        total++; if (bus_rvalid !== 1'b0 || bus_rdata !== 32'd0) begin
            bad++; $display("FAIL reset_bus: got valid=%b data=%h want 0 0", bus_rvalid, bus_rdata); end
        total++; if (ci_bus.ci_n !== 8'd0 || ci_bus.ci_value_a !== 32'd0 || ci_bus.ci_value_b !== 32'd0) begin
            bad++; $display("FAIL reset_operands: got n=%h a=%h b=%h want 0", ci_bus.ci_n,
                            ci_bus.ci_value_a, ci_bus.ci_value_b); end
        reset = 1'b0;
        @(negedge clock);
        bus_read(ADDR_CTRL, d, v);
        total++; if (d !== 32'd0 || v !== 1'b1) begin
            bad++; $display("FAIL reset_status: got %h valid=%b want 00000000 valid=1", d, v); end
        bus_read(ADDR_RESULT, d, v);
        total++; if (d !== 32'd0) begin
            bad++; $display("FAIL reset_result: got %h want 00000000", d); end
        m_a = 0; m_result = 0; m_done = 0; m_tmo = 0; m_irq_en = 0;
    endtask

    task automatic test_regs();
        logic [31:0] d, n_word, b; logic v;
        n_word = $urandom(); m_a = $urandom(); b = $urandom();
        bus_write(ADDR_CI_N, n_word);
        bus_write(ADDR_VALUE_A, m_a);
        bus_write(ADDR_VALUE_B, b);
        bus_write(3'd5, 32'hFFFF_FFFF);
        total++; if (ci_bus.ci_n !== n_word[7:0] || ci_bus.ci_value_a !== m_a || ci_bus.ci_value_b !== b) begin
            bad++; $display("FAIL regs_outputs: got n=%h a=%h b=%h want n=%h a=%h b=%h", ci_bus.ci_n,
                            ci_bus.ci_value_a, ci_bus.ci_value_b, n_word[7:0], m_a, b); end
        bus_read(ADDR_CI_N, d, v);
        total++; if (d !== {24'd0, n_word[7:0]}) begin
            bad++; $display("FAIL regs_read_n: got %h want %h", d, {24'd0, n_word[7:0]}); end
        bus_read(ADDR_VALUE_B, d, v);
        total++; if (d !== b) begin
            bad++; $display("FAIL regs_read_b: got %h want %h", d, b); end
        for (int a = 5; a <= 7; a++) begin
            bus_read(3'(a), d, v);
            total++; if (d !== 32'd0 || v !== 1'b1) begin
                bad++; $display("FAIL regs_unmapped_%0d: got %h valid=%b want 0 valid=1", a, d, v); end
        end
        @(negedge clock);
        total++; if (bus_rvalid !== 1'b0 || bus_rdata !== 32'd0) begin
            bad++; $display("FAIL regs_valid_drop: got valid=%b data=%h want 0 0", bus_rvalid, bus_rdata); end
    endtask

    task automatic test_delay_ci();
        int ns, nb, fs, ls; logic [31:0] ms, d; logic v;
        bus_write(ADDR_CI_N, 32'd3);
        m_a = 32'd5;
        bus_write(ADDR_VALUE_A, m_a);
        bus_write(ADDR_VALUE_B, 32'd0);
        m_irq_en = 1'b0;
        run_txn(8, 32'd0, 0, 0, ns, nb, fs, ls, ms);
        model_finish(8, 32'd0);
        total++; if (ns !== 1 || fs !== 1) begin
            bad++; $display("FAIL delay_start: got pulses=%0d at=%0d want 1 at 1", ns, fs); end
        total++; if (nb !== model_busy(8)) begin
            bad++; $display("FAIL delay_busy: got %0d want %0d", nb, model_busy(8)); end
        bus_read(ADDR_CTRL, d, v);
        total++; if (d !== model_status() || d !== 32'h2) begin
            bad++; $display("FAIL delay_status: got %h want %h", d, model_status()); end
        bus_read(ADDR_RESULT, d, v);
        total++; if (d !== m_result) begin
            bad++; $display("FAIL delay_result: got %h want %h", d, m_result); end
        total++; if (ci_bus.ci_n !== 8'd3 || ci_bus.ci_value_a !== 32'd5 || irq !== 1'b0) begin
            bad++; $display("FAIL delay_operands: got n=%h a=%h irq=%b want 03 5 0",
                            ci_bus.ci_n, ci_bus.ci_value_a, irq); end
    endtask

    task automatic test_comb_ci();
        int ns, nb, fs, ls; logic [31:0] ms, d; logic v;
        run_txn(1, 32'hDEAD_BEEF, 0, 0, ns, nb, fs, ls, ms);
        model_finish(1, 32'hDEAD_BEEF);
        total++; if (nb !== 1 || ns !== 1) begin
            bad++; $display("FAIL comb_busy: got busy=%0d pulses=%0d want 1 1", nb, ns); end
        bus_read(ADDR_RESULT, d, v);
        total++; if (d !== 32'hDEAD_BEEF) begin
            bad++; $display("FAIL comb_result: got %h want deadbeef", d); end
        bus_read(ADDR_CTRL, d, v);
        total++; if (d !== model_status()) begin
            bad++; $display("FAIL comb_status: got %h want %h", d, model_status()); end
    endtask

    task automatic test_timeout();
        int ns, nb, fs, ls; logic [31:0] ms, d; logic v;
        m_irq_en = 1'b1;
        run_txn(0, 32'd0, 0, 0, ns, nb, fs, ls, ms);
        model_finish(0, 32'd0);
        total++; if (nb !== TMO + 1) begin
            bad++; $display("FAIL timeout_busy: got %0d want %0d", nb, TMO + 1); end
        bus_read(ADDR_CTRL, d, v);
        total++; if (d !== model_status() || d !== 32'hC) begin
            bad++; $display("FAIL timeout_status: got %h want %h", d, model_status()); end
        bus_read(ADDR_RESULT, d, v);
        total++; if (d !== 32'd0) begin
            bad++; $display("FAIL timeout_result: got %h want 00000000", d); end
        total++; if (irq !== 1'b1) begin
            bad++; $display("FAIL timeout_irq: got %b want 1", irq); end
    endtask

    task automatic test_coincide();
        int ns, nb, fs, ls; logic [31:0] ms, d, val; logic v;
        val = $urandom();
        run_txn(TMO + 1, val, 0, 0, ns, nb, fs, ls, ms);
        model_finish(TMO + 1, val);
        bus_read(ADDR_CTRL, d, v);
        total++; if (d !== model_status() || d !== 32'hA) begin
            bad++; $display("FAIL coincide_status: got %h want %h", d, model_status()); end
        bus_read(ADDR_RESULT, d, v);
        total++; if (d !== val) begin
            bad++; $display("FAIL coincide_result: got %h want %h", d, val); end
    endtask

    task automatic test_busy_writes();
        int ns, nb, fs, ls; logic [31:0] ms, d, val; logic v;
        val = $urandom();
        run_txn(10, val, 1, ~m_a, ns, nb, fs, ls, ms);
        model_finish(10, val);
        total++; if (ns !== 1 || nb !== 10) begin
            bad++; $display("FAIL busy_single_start: got pulses=%0d busy=%0d want 1 10", ns, nb); end
        total++; if (ms !== {28'd0, m_irq_en, 3'b001}) begin
            bad++; $display("FAIL busy_mid_status: got %h want %h", ms, {28'd0, m_irq_en, 3'b001}); end
        bus_read(ADDR_VALUE_A, d, v);
        total++; if (d !== m_a || ci_bus.ci_value_a !== m_a) begin
            bad++; $display("FAIL busy_value_a: got %h/%h want %h", d, ci_bus.ci_value_a, m_a); end
    endtask

    task automatic test_clear();
        int ns, nb, fs, ls; logic [31:0] ms, d, val; logic v;
        bus_write(ADDR_CTRL, 32'h6);
        m_irq_en = 1'b1; m_done = 1'b0; m_tmo = 1'b0;
        bus_read(ADDR_CTRL, d, v);
        total++; if (d !== model_status() || irq !== 1'b0) begin
            bad++; $display("FAIL clear_flags: got %h irq=%b want %h irq=0", d, irq, model_status()); end
        val = $urandom();
        run_txn(6, val, 2, 0, ns, nb, fs, ls, ms);
        model_finish(6, val);
        bus_read(ADDR_CTRL, d, v);
        total++; if (d !== model_status() || irq !== 1'b1) begin
            bad++; $display("FAIL clear_vs_set: got %h irq=%b want %h irq=1", d, irq, model_status()); end
    endtask

    task automatic test_back_to_back();
        int ns, nb, fs, ls, lat; logic [31:0] ms, d; logic v;
        lat = $urandom_range(2, 9);
        run_txn(lat, $urandom(), 4, 0, ns, nb, fs, ls, ms);
        model_finish(0, 32'd0);
        total++; if (ns !== 2 || ls !== lat + 2 || nb !== lat) begin
            bad++; $display("FAIL b2b_starts: got pulses=%0d second=%0d busy=%0d want 2 %0d %0d",
                            ns, ls, nb, lat + 2, lat); end
        bus_read(ADDR_CTRL, d, v);
        total++; if (d !== model_status()) begin
            bad++; $display("FAIL b2b_status: got %h want %h", d, model_status()); end
    endtask

    task automatic test_random();
        int ns, nb, fs, ls, lat, poke; logic [31:0] ms, d, val; logic v;
        for (int i = 0; i < 20; i++) begin
            lat = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 24));
            val = $urandom();
            m_irq_en = 1'($urandom_range(0, 1));
            poke = 0;
            if (lat > 0 && $urandom_range(0, 1) == 1) poke = 3;
            if (model_done(lat) && $urandom_range(0, 3) == 0) poke = 2;
            m_a = $urandom();
            bus_write(ADDR_VALUE_A, m_a);
            run_txn(lat, val, poke, 0, ns, nb, fs, ls, ms);
            model_finish(lat, val);
            total++; if (ns !== 1 || fs !== 1 || nb !== model_busy(lat)) begin
                bad++; $display("FAIL rand%0d_timing: lat=%0d got pulses=%0d busy=%0d want 1 %0d",
                                i, lat, ns, nb, model_busy(lat)); end
            bus_read(ADDR_RESULT, d, v);
            total++; if (d !== m_result) begin
                bad++; $display("FAIL rand%0d_result: lat=%0d got %h want %h", i, lat, d, m_result); end
            bus_read(ADDR_CTRL, d, v);
            total++; if (d !== model_status() || irq !== (m_irq_en & (m_done | m_tmo))) begin
                bad++; $display("FAIL rand%0d_status: lat=%0d got %h irq=%b want %h", i, lat, d, irq,
                                model_status()); end
            total++; if (ci_bus.ci_value_a !== m_a) begin
                bad++; $display("FAIL rand%0d_value_a: got %h want %h", i, ci_bus.ci_value_a, m_a); end
        end
    endtask

    task automatic test_reset_wait();
        logic [31:0] d; logic v;
        bus_write(ADDR_CTRL, 32'h3);
        repeat (5) @(negedge clock);
        total++; if (ci_bus.ci_cke !== 1'b1) begin
            bad++; $display("FAIL rstwait_pre_cke: got %b want 1", ci_bus.ci_cke); end
        ci_bus.ci_result = 32'h1234_5678;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        total++; if (ci_bus.ci_cke !== 1'b0 || ci_bus.ci_start !== 1'b0 || irq !== 1'b0) begin
            bad++; $display("FAIL rstwait_outputs: got cke=%b start=%b irq=%b want 0 0 0",
                            ci_bus.ci_cke, ci_bus.ci_start, irq); end
        bus_read(ADDR_CTRL, d, v);
        total++; if (d !== 32'd0) begin
            bad++; $display("FAIL rstwait_status: got %h want 00000000", d); end
        bus_read(ADDR_RESULT, d, v);
        total++; if (d !== 32'd0) begin
            bad++; $display("FAIL rstwait_result: got %h want 00000000", d); end
    endtask

    initial begin
        reset = 1'b1; bus_we = 1'b0; bus_re = 1'b0; bus_addr = '0; bus_wdata = '0;
        ci_bus.ci_done = 1'b0; ci_bus.ci_result = '0;
        m_a = 0; m_result = 0; m_done = 0; m_tmo = 0; m_irq_en = 0;
        @(negedge clock);
        test_reset();
        test_regs();
        test_delay_ci();
        test_comb_ci();
        test_timeout();
        test_coincide();
        test_busy_writes();
        test_clear();
        test_back_to_back();
        test_random();
        test_reset_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ci_launcher.md
# ci_launcher

Issues custom instructions from a memory-mapped register port onto the single-clock custom-instruction (CI) interface. It drives `ciN`, `ciValueA`, `ciValueB`, `ciStart` and `ciCke` into CI blocks such as the microsecond delay element. It waits for `ciDone`, captures `ciResult`, and exposes completion through status bits and an interrupt. An optional watchdog aborts a transaction if `ciDone` never arrives.

## Interface
- `timeoutCycles`, default 32'd0: cycles allowed in WAIT before abort; 0 disables the watchdog.
- `clock` in 1: the single system clock, shared with the CI blocks.
- `reset` in 1: synchronous, active-high. One clock; reset is synchronous and active-high.
- `busAddress` in 3: register select. 0=CI_N, 1=VALUE_A, 2=VALUE_B, 3=CONTROL/STATUS, 4=RESULT; 5..7 read 0 and ignore writes.
- `busWriteEnable` in 1: write strobe, one cycle per write.
- `busWriteData` in 32: write data.
- `busReadEnable` in 1: read strobe, one cycle per read.
- `busReadData` out 32: read data; 0 when `busReadValid`=0.
- `busReadValid` out 1: pulses one cycle after `busReadEnable`.
- `ciStart` out 1: one-cycle start pulse.
- `ciCke` out 1: high from the ISSUE cycle through the cycle `ciDone` is accepted.
- `ciN` out 8: registered CI_N[7:0].
- `ciValueA` out 32: registered VALUE_A.
- `ciValueB` out 32: registered VALUE_B.
- `ciDone` in 1: completion from the addressed CI.
- `ciResult` in 32: result, valid while `ciDone`=1.
- `irq` out 1: `doneFlag` OR `timeoutFlag`, gated by `irqEnable`.

## Operation
- Reset values:
  - CI_N, VALUE_A, VALUE_B, RESULT = 0.
  - All flags = 0; FSM = IDLE.
  - All outputs = 0.
- CONTROL write fields:
  - bit0 start.
  - bit1 `irqEnable` (stored).
  - bit2 clear flags.
- STATUS read fields:
  - bit0 busy (state ≠ IDLE).
  - bit1 `doneFlag`.
  - bit2 `timeoutFlag`.
  - bit3 `irqEnable`.
  - bits 31:4 = 0.
- Writes to CI_N, VALUE_A and VALUE_B while busy are ignored.
- A start write while busy is ignored, but its `irqEnable` and clear bits still apply.
- FSM state IDLE: a start write moves to ISSUE and clears `doneFlag`, `timeoutFlag` and the watchdog counter.
- FSM state ISSUE (exactly one cycle): `ciStart`=1 and `ciCke`=1.
  - If `ciDone`=1 in this cycle, capture the result and return to IDLE. This covers combinational CIs.
  - Otherwise move to WAIT.
- FSM state WAIT: `ciCke`=1 and `ciStart`=0.
  - On `ciDone`=1, RESULT ← `ciResult`, `doneFlag` ← 1, return to IDLE.
  - Otherwise, if `timeoutCycles`≠0 and the counter equals `timeoutCycles`-1, set `timeoutFlag`, RESULT ← 0, return to IDLE.
  - Otherwise increment the counter.
- `ciDone` in the same cycle as the watchdog expiry: done wins, and `timeoutFlag` stays 0.
- `ciDone` while in IDLE is ignored.
- A clear write and a flag-setting event in the same cycle: the set wins.
- The watchdog counter is 32 bits and saturates; it never wraps.
- Reset mid-transaction returns to IDLE within one cycle. `ciStart` and `ciCke` drop on the next edge, and no result is captured.

## Timing
- Start write sampled at edge t:
  - `ciStart`/`ciCke` high during cycle t+1 (ISSUE).
  - WAIT from t+2.
- `ciDone` high during cycle d:
  - RESULT, `doneFlag` and `irq` update at edge d+1.
  - busy = 0 from d+1.
  - `ciCke` low from d+1.
- Read sampled at edge r: `busReadData`/`busReadValid` valid during cycle r+1. Reads are legal in any state.
- Back-to-back: a new start is accepted in the first IDLE cycle after completion.

## Structure
- Shared package `ci_launcher_pkg` holds:
  - register address constants;
  - CONTROL/STATUS bit positions;
  - the FSM state enum {IDLE, ISSUE, WAIT}.
- One sub-module is natural: `ci_timeout_counter`.
  - Inputs: `clock`, `reset`, `clear`, `enable`, limit.
  - Output: `expired`.
  - Saturating 32-bit count; `expired` is tied to 0 when the limit is 0.

## Test plan
- Delay-style CI with CI_N=8'd3, VALUE_A=5, VALUE_B=0; CI raises `ciDone` 7 cycles after start with `ciResult`=0 → single `ciStart` pulse at t+1, busy for 8 cycles, STATUS=32'h2, RESULT=0.
- Combinational CI with `ciDone`=1 in the ISSUE cycle and `ciResult`=32'hDEADBEEF → RESULT=32'hDEADBEEF, busy cleared at t+2, no WAIT cycle.
- `timeoutCycles`=16, CI never responds → `timeoutFlag` set after exactly 16 WAIT cycles, RESULT=0, `irq`=1 with `irqEnable`=1.
- `ciDone` coincides with the 16th WAIT cycle → `doneFlag`=1, `timeoutFlag`=0, RESULT=`ciResult`.
- Writes to VALUE_A and a second start while busy → VALUE_A unchanged, exactly one `ciStart` pulse.
- Reset asserted in WAIT → IDLE next edge, `ciCke`=0, STATUS=0, RESULT unchanged at 0.
